// File: rtl/branch_ctrl_32.sv
// Branch sequencer: reads the condition register, evaluates the 2-bit
// condition code and, when taken, reads the target register and loads PC.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   start, IR                branch request (sampled only when idle), instruction
//   busy                     high whenever a branch is in flight
//   rf_rd_req/addr/data/valid  register-file read port
//   pc_ld, pc_out            one-cycle PC load strobe and branch target
//   done, taken, err         one-cycle completion strobe with outcome/timeout
module branch_ctrl_32 #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       IR,
    output logic              busy,
    output logic              rf_rd_req,
    output logic [REG_AW-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    input  logic              rf_rd_valid,
    output logic              pc_ld,
    output logic [DATA_W-1:0] pc_out,
    output logic              done,
    output logic              taken,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_COND = 3'd1;
    localparam logic [2:0] S_EVAL    = 3'd2;
    localparam logic [2:0] S_RD_TGT  = 3'd3;
    localparam logic [2:0] S_LOAD_PC = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [1:0]        cond_q;
    logic [3:0]        ra_q;
    logic [3:0]        rb_q;
    logic [DATA_W-1:0] val_q;
    logic [DATA_W-1:0] pc_q;
    logic              taken_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              rd_active;
    logic              time_up;
    logic              eval_taken;

    assign rd_active = (state_q == S_RD_COND) || (state_q == S_RD_TGT);
    assign cnt_inc   = cnt_q + 1'b1;

    // Expires on the wait cycle that brings the count up to TIMEOUT;
    // a valid in that same cycle takes priority in the next-state logic.
    assign time_up = !rf_rd_valid && (cnt_inc == CNT_W'(TIMEOUT));

    // Evaluated from the registered condition value only, so there is
    // no combinational path from rf_rd_data to the outcome.
    always_comb begin
        eval_taken = 1'b0;
        unique case (cond_q)
            2'b00: eval_taken = (val_q == '0);
            2'b01: eval_taken = (val_q != '0);
            2'b10: eval_taken = !val_q[DATA_W-1];
            2'b11: eval_taken = val_q[DATA_W-1];
            default: eval_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RD_COND;
            end
            S_RD_COND: begin
                if (rf_rd_valid)  state_d = S_EVAL;
                else if (time_up) state_d = S_ERR;
            end
            S_EVAL: begin
                state_d = eval_taken ? S_RD_TGT : S_DONE;
            end
            S_RD_TGT: begin
                if (rf_rd_valid)  state_d = S_LOAD_PC;
                else if (time_up) state_d = S_ERR;
            end
            S_LOAD_PC: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cond_q  <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            val_q   <= '0;
            pc_q    <= '0;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == S_IDLE && start) begin
                cond_q  <= IR[20:19];
                ra_q    <= IR[26:23];
                rb_q    <= IR[18:15];
                taken_q <= 1'b0;
            end

            // Restart the wait count on every state change so each
            // read gets its own full timeout window.
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (rd_active && !rf_rd_valid) begin
                cnt_q <= cnt_inc;
            end

            if (state_q == S_RD_COND && rf_rd_valid) begin
                val_q <= rf_rd_data;
            end

            if (state_q == S_EVAL) begin
                taken_q <= eval_taken;
            end

            // Target lands in pc_q as LOAD_PC is entered and is held
            // there until the next taken branch.
            if (state_q == S_RD_TGT && rf_rd_valid) begin
                pc_q <= rf_rd_data;
            end
        end
    end

    always_comb begin
        rf_rd_addr = '0;
        unique case (1'b1)
            (state_q == S_RD_COND): rf_rd_addr = REG_AW'(ra_q);
            (state_q == S_RD_TGT):  rf_rd_addr = REG_AW'(rb_q);
            default:                rf_rd_addr = '0;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign rf_rd_req = rd_active;
    assign pc_ld     = (state_q == S_LOAD_PC);
    assign pc_out    = pc_q;
    assign done      = (state_q == S_DONE) || (state_q == S_ERR);
    assign taken     = (state_q == S_DONE) && taken_q;
    assign err       = (state_q == S_ERR);

endmodule
